// File: rtl/ah_credit_pkg.sv
// Shared types and defaults for credit-based senders.
package ah_credit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        SEND  = 2'd2
    } state_e;

    localparam int unsigned DEF_DW      = 140;
    localparam int unsigned DEF_CREDITS = 78;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    localparam int unsigned DEF_CW = clog2(DEF_CREDITS + 1);

endpackage

// File: rtl/ah_credit_counter.sv
// Local credit counter for a credit-based write port; saturates at CREDITS
// and flags any return that would exceed it.
module ah_credit_counter
    import ah_credit_pkg::*;
#(
    parameter int unsigned CREDITS = DEF_CREDITS,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume,
    input  logic          ret,
    output logic [CW-1:0] count,
    output logic          avail,
    output logic          ovf
);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (ret && !consume) begin
            if (count_q == CW'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (consume && !ret && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(CREDITS);
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign avail = (count_q != '0);
    assign ovf   = ovf_q;

endmodule

// File: rtl/ah_snoop_dedup_tx.sv
// Request feeder for a snoopable credit FIFO: snoops each request against the
// queued entries, drops duplicates, and pushes the rest under credit control.
module ah_snoop_dedup_tx
    import ah_credit_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned CREDITS  = DEF_CREDITS,
    parameter int unsigned CW       = clog2(CREDITS + 1),
    parameter bit          DEDUP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] wdata,
    output logic          wvalid,
    input  logic          wcredit,
    output logic [DW-1:0] sdata,
    output logic          svalid,
    input  logic          smatch,
    output logic [CW-1:0] credits_avail,
    output logic [15:0]   drop_cnt,
    output logic          err_credit_ovf
);

    state_e        state_q;
    logic [DW-1:0] hold_q;
    logic [15:0]   drop_q;
    logic          credit_avail;

    ah_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .consume (wvalid),
        .ret     (wcredit),
        .count   (credits_avail),
        .avail   (credit_avail),
        .ovf     (err_credit_ovf)
    );

    // Strobes are pure state decodes so the FIFO sees them in the state's cycle.
    assign in_ready = (state_q == IDLE);
    assign svalid   = (state_q == SNOOP);
    assign wvalid   = (state_q == SEND) && credit_avail;
    assign wdata    = hold_q;
    assign sdata    = hold_q;
    assign drop_cnt = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            drop_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        hold_q  <= in_data;
                        state_q <= DEDUP_EN ? SNOOP : SEND;
                    end
                end
                SNOOP: begin
                    if (smatch) begin
                        if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (credit_avail) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ah_snoop_dedup_tx.sv
// Directed bench for ah_snoop_dedup_tx: table-driven basic flow plus
// hand-written credit, overflow, reset and no-dedup sequences.
module tb_ah_snoop_dedup_tx;

    localparam int unsigned DW = 140;
    localparam int unsigned CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wcredit;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          smatch;
    logic [CW-1:0] credits_avail;
    logic [15:0]   drop_cnt;
    logic          err_credit_ovf;

    logic [DW-1:0] nd_in_data;
    logic          nd_in_valid;
    logic          nd_in_ready;
    logic [DW-1:0] nd_wdata;
    logic          nd_wvalid;
    logic          nd_wcredit;
    logic [DW-1:0] nd_sdata;
    logic          nd_svalid;
    logic          nd_smatch;
    logic [CW-1:0] nd_credits;
    logic [15:0]   nd_drop_cnt;
    logic          nd_err;
    logic          nd_sv_seen;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ah_snoop_dedup_tx #(.DW(DW), .CREDITS(78), .CW(CW), .DEDUP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wdata(wdata), .wvalid(wvalid), .wcredit(wcredit),
        .sdata(sdata), .svalid(svalid), .smatch(smatch),
        .credits_avail(credits_avail), .drop_cnt(drop_cnt),
        .err_credit_ovf(err_credit_ovf)
    );

    ah_snoop_dedup_tx #(.DW(DW), .CREDITS(78), .CW(CW), .DEDUP_EN(1'b0)) dut_nd (
        .clk(clk), .rst(rst), .in_data(nd_in_data), .in_valid(nd_in_valid),
        .in_ready(nd_in_ready), .wdata(nd_wdata), .wvalid(nd_wvalid),
        .wcredit(nd_wcredit), .sdata(nd_sdata), .svalid(nd_svalid),
        .smatch(nd_smatch), .credits_avail(nd_credits), .drop_cnt(nd_drop_cnt),
        .err_credit_ovf(nd_err)
    );

    always @(posedge clk) begin
        if (rst) nd_sv_seen <= 1'b0;
        else if (nd_svalid) nd_sv_seen <= 1'b1;
    end

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          smatch;
        logic          wcredit;
        logic          e_ready;
        logic          e_svalid;
        logic          e_wvalid;
        logic [CW-1:0] e_cred;
        logic [15:0]   e_drop;
        logic          chk_data;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Accept a request from IDLE; returns with the SNOOP decision taken.
    task automatic send_req(input logic [DW-1:0] d, input logic sm);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        smatch   = sm;
        tick();
        smatch   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; smatch = 1'b0; wcredit = 1'b0;
        nd_in_valid = 1'b0; nd_in_data = '0; nd_smatch = 1'b0; nd_wcredit = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_svalid", svalid, 1'b0);
        chk("rst_wdata", wdata, '0);
        chk("rst_sdata", sdata, '0);
        chk("rst_credits", credits_avail, 7'd78);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_ovf", err_credit_ovf, 1'b0);

        //       valid data      sm   wc   rdy  sv   wv   cred   drop  chkd data
        vt[0] = '{1'b1, 140'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd78, 16'd0, 1'b0, 140'h0};
        vt[1] = '{1'b0, 140'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd78, 16'd0, 1'b1, 140'h5A};
        vt[2] = '{1'b0, 140'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd78, 16'd0, 1'b1, 140'h5A};
        vt[3] = '{1'b1, 140'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd77, 16'd0, 1'b0, 140'h0};
        vt[4] = '{1'b0, 140'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd77, 16'd0, 1'b1, 140'h5A};
        vt[5] = '{1'b0, 140'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd77, 16'd1, 1'b0, 140'h0};
        vt[6] = '{1'b0, 140'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd77, 16'd1, 1'b0, 140'h0};

        for (int i = 0; i < 7; i++) begin
            tick();
            in_valid = vt[i].in_valid;
            in_data  = vt[i].in_data;
            smatch   = vt[i].smatch;
            wcredit  = vt[i].wcredit;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ready);
            chk($sformatf("v%0d_svalid", i), svalid, vt[i].e_svalid);
            chk($sformatf("v%0d_wvalid", i), wvalid, vt[i].e_wvalid);
            chk($sformatf("v%0d_credits", i), credits_avail, vt[i].e_cred);
            chk($sformatf("v%0d_drop", i), drop_cnt, vt[i].e_drop);
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d_wdata", i), wdata, vt[i].e_data);
                chk($sformatf("v%0d_sdata", i), sdata, vt[i].e_data);
            end
        end
        in_valid = 1'b0; smatch = 1'b0; wcredit = 1'b0;

        // Drain all 78 credits
        do_reset();
        nw = 0;
        for (int i = 0; i < 78; i++) begin
            send_req(DW'(i + 100), 1'b0);
            @(negedge clk);
            if (wvalid) nw++;
            tick();
        end
        chk("drain_wvalid_count", DW'(nw), DW'(78));
        @(negedge clk);
        chk("drain_credits", credits_avail, 7'd0);

        // 79th request stalls, one credit releases it
        tick();
        send_req(140'h79, 1'b0);
        @(negedge clk);
        chk("stall_wvalid", wvalid, 1'b0);
        chk("stall_in_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("stall_wvalid2", wvalid, 1'b0);
        wcredit = 1'b1;
        tick();
        wcredit = 1'b0;
        @(negedge clk);
        chk("release_wvalid", wvalid, 1'b1);
        chk("release_wdata", wdata, 140'h79);
        tick();
        @(negedge clk);
        chk("release_credits", credits_avail, 7'd0);
        chk("release_in_ready", in_ready, 1'b1);

        // Simultaneous credit return and push at credits=5
        wcredit = 1'b1;
        repeat (5) tick();
        wcredit = 1'b0;
        @(negedge clk);
        chk("refill_credits", credits_avail, 7'd5);
        send_req(140'hC5, 1'b0);
        wcredit = 1'b1;
        @(negedge clk);
        chk("both_wvalid", wvalid, 1'b1);
        tick();
        wcredit = 1'b0;
        @(negedge clk);
        chk("both_credits", credits_avail, 7'd5);

        // Credit overflow at full count
        do_reset();
        @(negedge clk);
        chk("ovf_before", err_credit_ovf, 1'b0);
        wcredit = 1'b1;
        tick();
        wcredit = 1'b0;
        @(negedge clk);
        chk("ovf_set", err_credit_ovf, 1'b1);
        chk("ovf_credits", credits_avail, 7'd78);
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_sticky", err_credit_ovf, 1'b1);

        // Drop one, then reset while in SEND
        tick();
        send_req(140'h5A, 1'b1);
        @(negedge clk);
        chk("pre_rst_drop", drop_cnt, 16'd1);
        tick();
        send_req(140'h1, 1'b0);
        @(negedge clk);
        chk("pre_rst_wdata", wdata, 140'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wvalid", wvalid, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_credits", credits_avail, 7'd78);
        chk("post_rst_drop", drop_cnt, 16'd0);
        chk("post_rst_ovf", err_credit_ovf, 1'b0);
        chk("post_rst_wdata", wdata, '0);
        repeat (2) tick();
        @(negedge clk);
        chk("post_rst_wvalid_later", wvalid, 1'b0);

        // No-dedup instance: wvalid one cycle after accept
        nd_in_valid = 1'b1;
        nd_in_data  = 140'hABC;
        tick();
        nd_in_valid = 1'b0;
        @(negedge clk);
        chk("nd_wvalid", nd_wvalid, 1'b1);
        chk("nd_wdata", nd_wdata, 140'hABC);
        chk("nd_svalid", nd_svalid, 1'b0);
        tick();
        @(negedge clk);
        chk("nd_credits", nd_credits, 7'd77);
        chk("nd_in_ready", nd_in_ready, 1'b1);
        chk("nd_svalid_never", nd_sv_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ah_snoop_dedup_tx.md
Name: ah_snoop_dedup_tx

Overview:
- Upstream feeder for the 140-bit, 78-entry snoopable credit FIFO.
- Accepts requests on a valid/ready interface.
- Before pushing a request, snoops the FIFO with it; if an identical entry is already queued, the request is dropped (deduplicated).
- Otherwise the request is pushed through the FIFO's credit-based write port, using a local credit counter sized to the FIFO depth.

Parameters:
- DW, 140, data width; must match the FIFO's data width.
- CREDITS, 78, FIFO depth; the initial and maximum credit count.
- CW, 7, credit counter width, equal to ceil(log2(CREDITS+1)).
- DEDUP_EN, 1, when 0 the SNOOP state is skipped and every request is sent.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- in_data  in  DW  request payload.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- wdata  out  DW  FIFO write data.
- wvalid  out  1  FIFO push strobe; one cycle per entry.
- wcredit  in  1  credit return pulse from the FIFO; one per freed entry.
- sdata  out  DW  snoop compare data.
- svalid  out  1  snoop request.
- smatch  in  1  combinational snoop result from the FIFO; valid in the same cycle as svalid.
- credits_avail  out  CW  current credit count.
- drop_cnt  out  16  number of deduplicated requests; saturates at 16'hFFFF.
- err_credit_ovf  out  1  sticky; set when a credit return would exceed CREDITS.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE, in_ready=1 (combinational from state).
  - wvalid=0, svalid=0, wdata=0, sdata=0.
  - credits=CREDITS, drop_cnt=0, err_credit_ovf=0.
  - Any held request is discarded.
  - The FIFO must be reset in the same cycle, so that credits match its empty state.
- Hold register hold_q is DW bits wide; wdata and sdata are driven from hold_q.
- State machine, with transitions taken at the clk edge:
  - IDLE:
    - in_ready=1.
    - On in_valid, capture in_data into hold_q.
    - Go to SNOOP if DEDUP_EN=1, else go to SEND.
  - SNOOP:
    - svalid=1 for exactly one cycle; sample smatch in that cycle.
    - smatch=1: drop the request, increment drop_cnt (saturating), go to IDLE.
    - smatch=0: go to SEND.
  - SEND:
    - wvalid=1 in every cycle where credits>0; decrement the credit, go to IDLE.
    - If credits==0, wvalid=0 and the block stays in SEND until a credit returns.
    - A credit returned in a given cycle is usable from the next cycle.
- Registering and throughput:
  - wvalid and svalid are combinational decodes of state and credits; they are registered only through state.
  - Latency from accept to wvalid is 2 cycles with dedup, 1 cycle without (when credits are available).
  - Throughput: one request per 3 cycles with DEDUP_EN=1, one per 2 cycles with DEDUP_EN=0.
- Credit arithmetic (per cycle):
  - next credits = credits + wcredit − (wvalid).
  - If wcredit and wvalid occur in the same cycle, credits are unchanged.
  - If wcredit=1 while credits==CREDITS and no wvalid: credits stay at CREDITS (saturate) and err_credit_ovf is set; it clears only on rst.
  - credits never underflows, because wvalid requires credits>0.
- Snoop coherence:
  - An entry pushed with wvalid in cycle N is visible to a snoop from cycle N+1 onward.
  - Because the FSM returns to IDLE between requests, back-to-back identical requests are always deduplicated.
- Outputs credits_avail and drop_cnt are registered.
- Nothing else writes the FIFO; other writers are outside the scope of this block.

Decomposition:
- Shared package ah_credit_pkg:
  - state enum {IDLE, SNOOP, SEND}.
  - default constants DW=140, CREDITS=78.
  - function clog2 used to derive CW.
- Sub-module ah_credit_counter:
  - parameters CREDITS, CW.
  - inputs: consume, ret.
  - outputs: count, avail (count>0), ovf.
  - synchronous reset to CREDITS.
  - Reusable by other credit-based senders.

Test Plan:
- Reset, then a single request 140'h5A with smatch=0:
  - svalid is high 1 cycle after accept.
  - wvalid with wdata=140'h5A is high the following cycle.
  - credits_avail drops from 78 to 77.
- Same request with smatch=1 in the SNOOP cycle:
  - no wvalid.
  - drop_cnt goes from 0 to 1.
  - in_ready returns to 1 the next cycle.
- Send 78 distinct requests with no wcredit:
  - credits_avail reaches 0.
  - The 79th request stalls in SEND with wvalid=0.
  - One wcredit pulse releases it: wvalid occurs the following cycle and credits_avail stays at 0.
- wcredit and wvalid in the same cycle with credits=5: credits_avail stays at 5.
- wcredit with credits=78 and the block idle:
  - err_credit_ovf=1 and credits_avail stays at 78.
  - The flag is held until rst.
- Assert rst while in SEND holding 140'h1:
  - no wvalid afterwards.
  - state returns to IDLE, credits_avail=78, drop_cnt=0.
  - With DEDUP_EN=0, a request produces wvalid 1 cycle after accept and svalid never asserts.
